key_schedule_iter: RTL

KEY_SCHEDULE_ITER -- requirements
Module: key_schedule_iter

---
 rtl/key_schedule_iter.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/key_schedule_iter.sv
// -----------------------------------------------------------------------------
// key_schedule_iter
//
// Iterative AES key expansion (AES-128/192/256). A start request latches the
// key and mode, one LOAD cycle copies the Nk key words into the word store,
// then EXPAND derives exactly one new word per cycle through a single shared
// SubWord unit. When done, the schedule is read as 128-bit round keys through
// a registered read port.
//
// Ports
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   expansion request, sampled only while idle
//   key_len   in   00=AES-128, 01=AES-192, 10=AES-256, 11=illegal
//   key       in   cipher key, MSB-first, word j at key[32*NK_MAX-1-32j -: 32]
//   busy      out  expansion in progress
//   done      out  one-cycle pulse, schedule complete
//   err       out  one-cycle pulse, start with illegal key_len
//   rk_valid  out  stored schedule complete and consistent
//   rk_addr   in   round-key index
//   rk_out    out  registered round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}
//   nr_out    out  round count of the latched mode
// -----------------------------------------------------------------------------
module key_schedule_iter #(
    parameter int NK_MAX = 8,
    parameter int NR_MAX = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            key_len,
    input  logic [32*NK_MAX-1:0]  key,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  rk_valid,
    input  logic [3:0]            rk_addr,
    output logic [127:0]          rk_out,
    output logic [3:0]            nr_out
);

    // Word store depth; rk_addr is 4 bits so the index never needs more than 6.
    localparam int NW = 4 * (NR_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EXPAND
    } state_t;

    // ------------------------------------------------------------------
    // GF(2^8) helpers for the S-box (inverse followed by affine map)
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse (and maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(x3, x3);
        x12  = gf_mul(x12, x12);
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] s;
        s = gf_inv(a);
        return s ^ {s[6:0], s[7]} ^ {s[5:0], s[7:6]} ^ {s[4:0], s[7:5]}
                 ^ {s[3:0], s[7:4]} ^ 8'h63;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [32*NK_MAX-1:0] r_key;
    logic [3:0]          r_nk;
    logic [3:0]          r_nr;
    logic [5:0]          r_i;
    logic [2:0]          r_phase;      // i mod Nk, tracked incrementally
    logic [7:0]          r_rcon;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                r_valid;
    logic [127:0]        r_rk_out;
    logic [31:0]         r_store [NW];

    logic [5:0]          w_last;
    logic [31:0]         w_prev;
    logic [31:0]         w_back;
    logic [31:0]         w_sub_in;
    logic [31:0]         w_sub;
    logic [31:0]         w_temp;
    logic [31:0]         w_new;
    logic [3:0]          w_rd_addr;
    logic                w_rd_ok;
    logic                w_accept;

    assign w_last    = {r_nr, 2'b11};                 // 4*(Nr+1)-1
    assign w_prev    = r_store[r_i - 6'd1];
    assign w_back    = r_store[r_i - {2'b00, r_nk}];
    assign w_sub_in  = (r_phase == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    assign w_new     = w_back ^ w_temp;
    assign w_rd_ok   = r_valid && (rk_addr <= r_nr);
    // Clamp so the read mux never indexes past the store; the result is
    // masked to zero in that case anyway.
    assign w_rd_addr = (rk_addr <= r_nr) ? rk_addr : 4'd0;
    assign w_accept  = (r_state == S_IDLE) && start && (key_len != 2'b11);

    // The one shared SubWord unit: four S-boxes.
    always_comb begin
        w_sub = '0;
        for (int b = 0; b < 4; b++) begin
            w_sub[8*b +: 8] = sbox(w_sub_in[8*b +: 8]);
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        w_temp = w_prev;
        if (r_phase == 3'd0) begin
            w_temp = w_sub ^ {r_rcon, 24'h000000};
        end else if (r_nk == 4'd8 && r_phase == 3'd4) begin
            w_temp = w_sub;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state  <= S_IDLE;
            r_nk     <= 4'd0;
            r_nr     <= 4'd0;
            r_i      <= 6'd0;
            r_phase  <= 3'd0;
            r_rcon   <= 8'h00;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_valid  <= 1'b0;
            r_rk_out <= '0;
        end else begin
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_rk_out <= w_rd_ok ? {r_store[{w_rd_addr, 2'b00}], r_store[{w_rd_addr, 2'b01}],
                                   r_store[{w_rd_addr, 2'b10}], r_store[{w_rd_addr, 2'b11}]}
                                : '0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (key_len == 2'b11) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state <= S_LOAD;
                            r_busy  <= 1'b1;
                            r_valid <= 1'b0;
                            r_nk    <= 4'd4 + {1'b0, key_len, 1'b0};
                            r_nr    <= 4'd10 + {1'b0, key_len, 1'b0};
                        end
                    end
                end
                S_LOAD: begin
                    r_i     <= {2'b00, r_nk};
                    r_phase <= 3'd0;
                    r_rcon  <= 8'h01;
                    r_state <= S_EXPAND;
                end
                S_EXPAND: begin
                    r_i     <= r_i + 6'd1;
                    r_phase <= ({1'b0, r_phase} == r_nk - 4'd1) ? 3'd0 : r_phase + 3'd1;
                    if (r_phase == 3'd0) r_rcon <= xtime(r_rcon);
                    // busy drops while the final word is being written, so it
                    // covers LOAD plus all but the last expansion cycle.
                    if (r_i == w_last - 6'd1) r_busy <= 1'b0;
                    if (r_i == w_last) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_valid <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Key latch and word store
    // ------------------------------------------------------------------
    // NOTE: the key latch and word store carry no reset; rk_valid masks
    // stale contents, and leaving them out keeps the store a plain RAM.
    always_ff @(posedge clk) begin
        if (w_accept) r_key <= key;
        if (r_state == S_LOAD) begin
            for (int j = 0; j < NK_MAX; j++) begin
                if (j < int'(r_nk)) r_store[j] <= r_key[32*NK_MAX-1-32*j -: 32];
            end
        end else if (r_state == S_EXPAND) begin
            r_store[r_i] <= w_new;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign rk_valid = r_valid;
    assign rk_out   = r_rk_out;
    assign nr_out   = r_nr;

endmodule
